// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: add/sub in one cycle, shift-add multiply and restoring
// divide over WIDTH iterations, with valid/ready handshakes on input and output.
module seq_alu #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_zero,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends combinationally on ready, and the producer holds data until then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 div_zero_q, div_zero_d;

  // Divider: partial remainder in acc_q[WIDTH-1:0], dividend/quotient shifts through sh_q.
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_sub;
  logic                 rem_ge;

  assign rem_sh  = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, opb_q});
  assign rem_sub = rem_sh - {1'b0, opb_q};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          opb_d = b;
          acc_d = '0;
          sh_d  = {{WIDTH{1'b0}}, a};
          cnt_d = '0;
          case (op)
            OP_ADD: begin
              result_d   = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
              div_zero_d = 1'b0;
              state_d    = DONE;
            end
            OP_SUB: begin
              result_d   = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
              div_zero_d = 1'b0;
              state_d    = DONE;
            end
            OP_MUL: state_d = CALC;
            OP_DIV: begin
              if (b == '0) begin
                result_d   = {a, {WIDTH{1'b1}}};
                div_zero_d = 1'b1;
                state_d    = DONE;
              end else begin
                state_d = CALC;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end

      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = opb_q[0] ? (acc_q + sh_q) : acc_q;
          sh_d  = sh_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = rem_ge ? {{(WIDTH-1){1'b0}}, rem_sub} : {{(WIDTH-1){1'b0}}, rem_sh};
          sh_d  = {sh_q[2*WIDTH-2:0], rem_ge};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d   = (op_q == OP_MUL) ? acc_d : {acc_d[WIDTH-1:0], sh_d[WIDTH-1:0]};
          div_zero_d = 1'b0;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      acc_q      <= '0;
      sh_q       <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = result_q;
  assign div_zero    = div_zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed scenarios plus random operations checked against an
// arithmetic reference model and an expected-result queue.
module tb_seq_alu;
  localparam int W  = 8;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    op = '0;
  logic          in_ready;
  logic          out_valid;
  logic [RW-1:0] result;
  logic          div_zero;
  logic          busy;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_zero   (div_zero),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [RW-1:0] ref_result(input int unsigned av, input int unsigned bv,
                                                input int unsigned opv);
    int unsigned r;
    case (opv)
      0: r = av + bv;
      1: r = av * bv;
      2: r = av - bv;
      default: r = (bv == 0) ? ((av << W) | ((1 << W) - 1)) : (((av % bv) << W) | (av / bv));
    endcase
    return RW'(r);
  endfunction

  function automatic logic ref_dz(input int unsigned bv, input int unsigned opv);
    return (opv == 3) && (bv == 0);
  endfunction

  function automatic int ref_lat(input int unsigned bv, input int unsigned opv);
    return (opv == 1 || (opv == 3 && bv != 0)) ? W + 1 : 1;
  endfunction

  // driver: called #1 after an edge; returns #1 after the edge where out_valid appeared
  task automatic send_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] opv,
                         output int lat, output logic [RW-1:0] res, output logic dz,
                         output logic side_ok);
    int guard;
    side_ok = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = av; b = bv; op = opv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 50) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) side_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0 || busy !== 1'b1) side_ok = 1'b0;
    if (out_valid !== 1'b1) lat = -1;
    res = result;
    dz = div_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_add();
    int lat; logic [RW-1:0] res, e; logic dz, ok;
    exp_q.push_back(ref_result(200, 100, 0));
    send_op(8'd200, 8'd100, 2'd0, lat, res, dz, ok);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL add_result: got %h expected %h", res, e); end
    checks++; if (res !== 16'h012C) begin errors++; $display("FAIL add_const: got %h expected 012c", res); end
    checks++; if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL add_div_zero: got %b expected 0", dz); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL add_back_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_mul();
    int lat; logic [RW-1:0] res, e; logic dz, ok;
    exp_q.push_back(ref_result(255, 255, 1));
    send_op(8'd255, 8'd255, 2'd1, lat, res, dz, ok);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL mul_result: got %h expected %h", res, e); end
    checks++; if (lat != W + 1) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mul_busy: got side_ok=%b expected 1", ok); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_div();
    int lat; logic [RW-1:0] res; logic dz, ok;
    send_op(8'd3, 8'd5, 2'd2, lat, res, dz, ok);
    checks++; if (res !== 16'hFFFE) begin errors++; $display("FAIL sub_wrap: got %h expected fffe", res); end
    @(posedge clk); #1;
    send_op(8'd100, 8'd7, 2'd3, lat, res, dz, ok);
    checks++; if (res[7:0] !== 8'd14) begin errors++; $display("FAIL div_quot: got %0d expected 14", res[7:0]); end
    checks++; if (res[15:8] !== 8'd2) begin errors++; $display("FAIL div_rem: got %0d expected 2", res[15:8]); end
    checks++; if (lat != W + 1) begin errors++; $display("FAIL div_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_div_zero: got %b expected 0", dz); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat; logic [RW-1:0] res; logic dz, ok;
    send_op(8'd42, 8'd0, 2'd3, lat, res, dz, ok);
    checks++; if (res !== 16'h2AFF) begin errors++; $display("FAIL dz_result: got %h expected 2aff", res); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", dz); end
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    @(posedge clk); #1;
    send_op(8'd1, 8'd2, 2'd0, lat, res, dz, ok);
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL dz_cleared: got %b expected 0", dz); end
    checks++; if (res !== 16'd3) begin errors++; $display("FAIL dz_next_add: got %h expected 3", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [RW-1:0] res, e; logic dz, ok;
    out_ready = 1'b0;
    exp_q.push_back(ref_result(13, 11, 1));
    send_op(8'd13, 8'd11, 2'd1, lat, res, dz, ok);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL bp_result: got %h expected %h", res, e); end
    a = 8'd50; b = 8'd60; op = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== e || out_valid !== 1'b1 || in_ready !== 1'b0 || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got result=%h ov=%b ir=%b dz=%b expected %h/1/0/0",
                 i, result, out_valid, in_ready, div_zero, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== e) begin
      errors++; $display("FAIL bp_release: got ov=%b ir=%b result=%h expected 0/1/%h", out_valid, in_ready, result, e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== ref_result(50, 60, 0)) begin
      errors++; $display("FAIL bp_queued: got ov=%b result=%h expected 1/%h", out_valid, result, ref_result(50, 60, 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [RW-1:0] res; logic dz, ok; logic seen;
    a = 8'd100; b = 8'd7; op = 2'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== '0 || div_zero !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got ov=%b ir=%b busy=%b result=%h dz=%b expected 0/1/0/0/0",
                         out_valid, in_ready, busy, result, div_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_output: got out_valid seen=%b expected 0", seen); end
    send_op(8'd17, 8'd25, 2'd0, lat, res, dz, ok);
    checks++; if (res !== 16'd42 || lat != 1) begin
      errors++; $display("FAIL rst_mid_new_op: got result=%h lat=%0d expected 002a/1", res, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [RW-1:0] res, e; logic dz, ok;
    logic [W-1:0] av, bv; logic [1:0] opv;
    for (int i = 0; i < 40; i++) begin
      opv = 2'($urandom_range(0, 3));
      av  = W'($urandom_range(0, 255));
      bv  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, 255));
      exp_q.push_back(ref_result(av, bv, opv));
      send_op(av, bv, opv, lat, res, dz, ok);
      e = exp_q.pop_front();
      checks++; if (res !== e) begin errors++; $display("FAIL rand_result: a=%0d b=%0d op=%0d got %h expected %h", av, bv, opv, res, e); end
      checks++; if (dz !== ref_dz(av == av ? bv : bv, opv)) begin errors++; $display("FAIL rand_div_zero: a=%0d b=%0d op=%0d got %b", av, bv, opv, dz); end
      checks++; if (lat != ref_lat(bv, opv)) begin errors++; $display("FAIL rand_latency: op=%0d b=%0d got %0d expected %0d", opv, bv, lat, ref_lat(bv, opv)); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL rand_idle: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_sub_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
